axi4_stream_fifo: RTL and testbench

Synchronous single-clock FIFO for AXI4-Stream traffic, placed on any `axi4_stream_if` link that needs elastic buffering between a producer and a consumer. It stores every sideband field (`tdata`, `tstrb`, `tkeep`, `tlast`, `tid`, `tdest`, `tuser`) together with the data. It decouples `tready` backpressure across the link at a sustained rate of one word per cycle.

---
 rtl/axi4_stream_fifo_pkg.sv | 25 ++
 rtl/axi4_stream_if.sv | 20 ++
 rtl/axi4_stream_fifo_ram.sv | 24 ++
 rtl/axi4_stream_fifo.sv | 111 +++++++++++
 tb/tb_axi4_stream_fifo.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_fifo_pkg.sv
// rtl/axi4_stream_fifo_pkg.sv - stored-word layout helpers for axi4_stream_fifo
package axi4_stream_fifo_pkg;

  function automatic int fifo_word_width(input int data_w, input int id_w,
                                         input int dest_w, input int user_w);
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

  // tlast sits just above {tid, tdest, tuser} in the stored word
  function automatic int fifo_last_bit(input int id_w, input int dest_w, input int user_w);
    return id_w + dest_w + user_w;
  endfunction

  // Field order of a stored word, MSB first, shown at the default widths
  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [7:0]  tid;
    logic [3:0]  tdest;
    logic [0:0]  tuser;
  } fifo_word_default_t;

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream link bundle with master/slave views
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
  modport slave  (input tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/axi4_stream_fifo_ram.sv
// rtl/axi4_stream_fifo_ram.sv - simple dual-port RAM, synchronous read, no reset
module axi4_stream_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read data holds until the next read, so it doubles as the in-flight slot
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/axi4_stream_fifo.sv
// rtl/axi4_stream_fifo.sv - single-clock AXI4-Stream FIFO with show-ahead output register
// Define AXI4_STREAM_FIFO_PKT_EN to hold data back until a whole packet is stored.
module axi4_stream_fifo
  import axi4_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_WIDTH   = 4,
  parameter int USER_WIDTH   = 1,
  parameter int WORDS_AMOUNT = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  axi4_stream_if.slave                  pkt_i,
  axi4_stream_if.master                 pkt_o,
  output logic [$clog2(WORDS_AMOUNT):0] used_words_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int WW = fifo_word_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int AW = $clog2(WORDS_AMOUNT);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(WORDS_AMOUNT);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   used_q, used_d;
  logic          full_q, pend_q, pend_d, out_valid_q;
  logic [WW-1:0] out_word_q, wr_word, rd_word;
  logic          wr_en, rd_en, rd_allow, load_ok;

  assign pkt_i.tready = !full_q && !rst_i;
  assign wr_en   = pkt_i.tvalid && pkt_i.tready;
  assign wr_word = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                    pkt_i.tid, pkt_i.tdest, pkt_i.tuser};
  assign load_ok = !out_valid_q || pkt_o.tready;
  // A new read may issue whenever the in-flight word moves out this cycle
  assign rd_en   = (used_q != '0) && rd_allow && (!pend_q || load_ok);
  assign pend_d  = rd_en || (pend_q && !load_ok);

  always_comb begin
    used_d = used_q;
    if (wr_en && !rd_en)      used_d = used_q + (AW+1)'(1);
    else if (!wr_en && rd_en) used_d = used_q - (AW+1)'(1);
  end

`ifdef AXI4_STREAM_FIFO_PKT_EN
  localparam int LAST_BIT = fifo_last_bit(ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  logic [AW+1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr_en && pkt_i.tlast;
  assign pkt_out = out_valid_q && pkt_o.tready && out_word_q[LAST_BIT];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_in && !pkt_out)      pkt_cnt_d = pkt_cnt_q + (AW+2)'(1);
    else if (!pkt_in && pkt_out) pkt_cnt_d = pkt_cnt_q - (AW+2)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  // full_q forces reads so a packet longer than the RAM cannot deadlock
  assign rd_allow = (pkt_cnt_q != '0) || full_q;
`else
  assign rd_allow = 1'b1;
`endif

  axi4_stream_fifo_ram #(
    .WIDTH (WW),
    .DEPTH (WORDS_AMOUNT)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      full_q      <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      used_q <= used_d;
      full_q <= (used_d == FULL_CNT);
      pend_q <= pend_d;
      if (load_ok) begin
        out_valid_q <= pend_q;
        if (pend_q) out_word_q <= rd_word;
      end
    end
  end

  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast,
          pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = out_word_q;
  assign pkt_o.tvalid  = out_valid_q;
  assign used_words_o  = used_q;
  assign full_o        = full_q;
  assign empty_o       = (used_q == '0) && !out_valid_q;
endmodule

// File: tb/tb_axi4_stream_fifo.sv
// tb/tb_axi4_stream_fifo.sv - self-checking bench for axi4_stream_fifo
// Packet-mode sequences run when AXI4_STREAM_FIFO_PKT_EN is defined.
module tb_axi4_stream_fifo;
  localparam int DW = 32, IW = 8, DSW = 4, UW = 1, DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic [DW/8-1:0] keep;
    logic            last;
    logic [IW-1:0]   id;
    logic [DSW-1:0]  dest;
    logic [UW-1:0]   user;
  } beat_t;

  typedef struct {
    logic  in_valid;
    beat_t in_beat;
    logic  out_ready;
    logic  exp_valid;
    beat_t exp_beat;
    logic  exp_in_ready;
    int    exp_used;
    logic  exp_empty;
    logic  exp_full;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] used_words;
  logic          full, empty;
  int            n_tests = 0;
  int            n_fail  = 0;

  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) out_if ();

  axi4_stream_fifo #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .WORDS_AMOUNT(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pkt_i        (in_if),
    .pkt_o        (out_if),
    .used_words_o (used_words),
    .full_o       (full),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                               input logic l, input logic [7:0] id, input logic [3:0] dst,
                               input logic u);
    beat_t b;
    b.data = d; b.strb = s; b.keep = k; b.last = l; b.id = id; b.dest = dst; b.user = u;
    return b;
  endfunction

  function automatic beat_t rand_beat(input int idx, input int n, input bit last_only_end);
    beat_t b;
    b.data = $urandom;
    b.strb = 4'($urandom);
    b.keep = 4'($urandom);
    b.id   = 8'($urandom);
    b.dest = 4'($urandom);
    b.user = 1'($urandom);
    if (idx == n - 1)   b.last = 1'b1;
    else if (last_only_end) b.last = 1'b0;
    else                b.last = ($urandom_range(3) == 0);
    return b;
  endfunction

  function automatic vec_t row(input logic iv, input beat_t ib, input logic ordy, input logic ev,
                               input beat_t eb, input logic eir, input int eu, input logic ee,
                               input logic ef);
    vec_t v;
    v.in_valid = iv; v.in_beat = ib; v.out_ready = ordy; v.exp_valid = ev; v.exp_beat = eb;
    v.exp_in_ready = eir; v.exp_used = eu; v.exp_empty = ee; v.exp_full = ef;
    return v;
  endfunction

  task automatic drive_in(input logic v, input beat_t b);
    in_if.tvalid = v;
    {in_if.tdata, in_if.tstrb, in_if.tkeep, in_if.tlast, in_if.tid, in_if.tdest, in_if.tuser} = b;
  endtask

  function automatic beat_t out_beat();
    return {out_if.tdata, out_if.tstrb, out_if.tkeep, out_if.tlast,
            out_if.tid, out_if.tdest, out_if.tuser};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_in(1'b0, '0);
    out_if.tready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_tvalid", out_if.tvalid, 0);
    check("rst_word", out_beat(), 0);
    check("rst_used", used_words, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_if.tready, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_if.tready, 1);
  endtask

  // Reference: a queue of accepted-but-unpopped words; the DUT must return them in order
  task automatic run_stream(input int n_words, input int vpct, input int rpct,
                            input bit last_only_end, input int budget, output bit full_first);
    beat_t q[$];
    beat_t nb, cur, prev, exp;
    int    sent = 0, rcvd = 0, cyc = 0;
    bit    stall_prev = 0, seen_full = 0, first = 1;
    full_first = 0;
    prev = '0;
    nb = rand_beat(0, n_words, last_only_end);
    while (rcvd < n_words && cyc < budget) begin
      @(negedge clk);
      drive_in((sent < n_words) && ($urandom_range(99) < vpct), nb);
      out_if.tready = ($urandom_range(99) < rpct);
      #1;
      cur = out_beat();
      if (stall_prev) begin
        check("stall_tvalid", out_if.tvalid, 1);
        check("stall_word", cur, prev);
      end
      if (full) seen_full = 1;
      check("full_vs_used", full, used_words == CW'(DEPTH));
      check("used_le_held", int'(used_words) <= q.size(), 1);
      check("held_le_capacity", q.size() <= DEPTH + 2, 1);
      if (q.size() == 0) check("empty_when_none_held", empty, 1);
      if (out_if.tvalid && out_if.tready) begin
        if (q.size() == 0) begin
          check("spurious_word", 1, 0);
        end else begin
          exp = q.pop_front();
          check($sformatf("stream_word%0d", rcvd), cur, exp);
          if (first) full_first = seen_full;
          first = 0;
          rcvd++;
        end
      end
      if (in_if.tvalid && in_if.tready) begin
        q.push_back(nb);
        sent++;
        nb = rand_beat(sent, n_words, last_only_end);
      end
      stall_prev = out_if.tvalid && !out_if.tready;
      prev = cur;
      cyc++;
    end
    @(negedge clk);
    drive_in(1'b0, '0);
    check("stream_count", rcvd, n_words);
  endtask

  initial begin
    vec_t  vec[11];
    beat_t b0, ba, bb, z, b;
    beat_t pk[4];
    int    acc, rx;
    bit    ff;

    z  = '0;
    b0 = mk(32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 8'h5A, 4'h3, 1'b1);
    ba = mk(32'h11111111, 4'h3, 4'h3, 1'b1, 8'h01, 4'h0, 1'b0);
    bb = mk(32'h22222222, 4'hC, 4'hF, 1'b1, 8'hA5, 4'hF, 1'b1);
    //              iv  in  ordy ev  exp  irdy used empty full
    vec[0]  = row(1'b1, b0, 1'b1, 1'b0, z,  1'b1, 0, 1'b1, 1'b0);
    vec[1]  = row(1'b0, z,  1'b1, 1'b0, z,  1'b1, 1, 1'b0, 1'b0);
    vec[2]  = row(1'b0, z,  1'b1, 1'b0, z,  1'b1, 0, 1'b1, 1'b0);
    vec[3]  = row(1'b0, z,  1'b1, 1'b1, b0, 1'b1, 0, 1'b0, 1'b0);
    vec[4]  = row(1'b1, ba, 1'b0, 1'b0, z,  1'b1, 0, 1'b1, 1'b0);
    vec[5]  = row(1'b1, bb, 1'b0, 1'b0, z,  1'b1, 1, 1'b0, 1'b0);
    vec[6]  = row(1'b0, z,  1'b0, 1'b0, z,  1'b1, 1, 1'b0, 1'b0);
    vec[7]  = row(1'b0, z,  1'b0, 1'b1, ba, 1'b1, 0, 1'b0, 1'b0);
    vec[8]  = row(1'b0, z,  1'b1, 1'b1, ba, 1'b1, 0, 1'b0, 1'b0);
    vec[9]  = row(1'b0, z,  1'b1, 1'b1, bb, 1'b1, 0, 1'b0, 1'b0);
    vec[10] = row(1'b0, z,  1'b1, 1'b0, z,  1'b1, 0, 1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_in(vec[i].in_valid, vec[i].in_beat);
      out_if.tready = vec[i].out_ready;
      #1;
      check($sformatf("vec%0d_tvalid", i), out_if.tvalid, vec[i].exp_valid);
      if (vec[i].exp_valid) check($sformatf("vec%0d_word", i), out_beat(), vec[i].exp_beat);
      check($sformatf("vec%0d_in_ready", i), in_if.tready, vec[i].exp_in_ready);
      check($sformatf("vec%0d_used", i), used_words, vec[i].exp_used);
      check($sformatf("vec%0d_empty", i), empty, vec[i].exp_empty);
      check($sformatf("vec%0d_full", i), full, vec[i].exp_full);
    end

    // Fill against a stalled consumer: 16 in RAM + in-flight + output register
    do_reset();
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      b = mk(32'h1000 + acc, 4'hF, 4'hF, acc == 17, 8'(acc), 4'(acc), 1'b0);
      drive_in(1'b1, b);
      out_if.tready = 1'b0;
      #1;
      if (in_if.tready) acc++;
    end
    @(negedge clk);
    drive_in(1'b0, '0);
    #1;
    check("fill_accepted", acc, 18);
    check("fill_full", full, 1);
    check("fill_used", used_words, DEPTH);
    check("fill_in_ready", in_if.tready, 0);
    check("fill_tvalid", out_if.tvalid, 1);
    rx = 0;
    for (int c = 0; c < 100 && rx < 18; c++) begin
      @(negedge clk);
      out_if.tready = 1'b1;
      #1;
      if (out_if.tvalid) begin
        check($sformatf("drain_word%0d", rx), out_beat(),
              mk(32'h1000 + rx, 4'hF, 4'hF, rx == 17, 8'(rx), 4'(rx), 1'b0));
        rx++;
      end
    end
    check("drain_count", rx, 18);

    // One-cycle reset with a partial packet buffered
    @(negedge clk);
    out_if.tready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      drive_in(1'b1, mk(32'h2000 + c, 4'hF, 4'hF, 1'b0, 8'(c), 4'h1, 1'b0));
    end
    @(negedge clk);
    drive_in(1'b0, '0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", in_if.tready, 0);
    @(negedge clk);
    #1;
    check("midrst_tvalid", out_if.tvalid, 0);
    check("midrst_used", used_words, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_high", in_if.tready, 1);
    run_stream(3, 100, 100, 1'b0, 100, ff);

    run_stream(4000, 50, 50, 1'b0, 40000, ff);

`ifdef AXI4_STREAM_FIFO_PKT_EN
    // Nothing may appear until two cycles after the tlast word is accepted
    do_reset();
    out_if.tready = 1'b1;
    for (int k = 0; k < 4; k++) pk[k] = mk(32'h3000 + k, 4'hF, 4'h7, k == 3, 8'(k), 4'h2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        drive_in(s == 0, pk[k]);
        #1;
        check($sformatf("pkt_hold_k%0d_s%0d", k, s), out_if.tvalid, 0);
      end
    end
    @(negedge clk);
    drive_in(1'b0, '0);
    #1;
    check("pkt_release_tvalid", out_if.tvalid, 1);
    rx = 0;
    for (int c = 0; c < 20 && rx < 4; c++) begin
      if (c != 0) begin
        @(negedge clk);
        #1;
      end
      if (out_if.tvalid) begin
        check($sformatf("pkt_word%0d", rx), out_beat(), pk[rx]);
        rx++;
      end
    end
    check("pkt_count", rx, 4);

    // A packet longer than the RAM must drain through the forced cut-through
    do_reset();
    run_stream(40, 100, 100, 1'b1, 2000, ff);
    check("long_pkt_full_before_output", ff, 1);
`else
    b = '0;
    pk[0] = b;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
